// File: rtl/uart_msg_builder.sv
// uart_msg_builder: formats one telemetry message into a 14-byte ASCII frame
// "#T-NN-VVVV-CC\n" and then runs the start/done handshake with the UART
// transmit wrapper. The value is converted to decimal by a sequential
// double-dabble. CC is the XOR of bytes 1..10 as two uppercase hex characters.
//
// Handshake with the transmit wrapper:
//   send_start is a level held high for START_HOLD cycles and then dropped.
//   send_done is a level that the wrapper raises once the frame is out.
//   The first edge that samples send_done high while in WAIT ends the transfer.
//   done then pulses for exactly one cycle.
//   req is a one-cycle strobe. It is honoured only in IDLE; while busy it is dropped.
module uart_msg_builder #(
    parameter int START_HOLD = 32
) (
    input  logic        clk_50M,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  msg_type,
    input  logic [3:0]  node_id,
    input  logic [11:0] value,
    input  logic        send_done,
    output logic        send_start,
    output logic [7:0]  data0,
    output logic [7:0]  data1,
    output logic [7:0]  data2,
    output logic [7:0]  data3,
    output logic [7:0]  data4,
    output logic [7:0]  data5,
    output logic [7:0]  data6,
    output logic [7:0]  data7,
    output logic [7:0]  data8,
    output logic [7:0]  data9,
    output logic [7:0]  data10,
    output logic [7:0]  data11,
    output logic [7:0]  data12,
    output logic [7:0]  data13,
    output logic        busy,
    output logic        done,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CONV  = 3'd1,
        S_ASM   = 3'd2,
        S_CKS   = 3'd3,
        S_FIN   = 3'd4,
        S_START = 3'd5,
        S_WAIT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t      state_q;
    logic [1:0]  type_q;
    logic [3:0]  node_q;
    logic [27:0] sr_q;      // {bcd[15:0], binary[11:0]} double-dabble register
    logic [27:0] sr_d;
    logic [15:0] cnt_q;     // shared step counter: CONV shifts, CKS byte index, START hold
    logic [7:0]  cks_q;
    logic [7:0]  cks_byte_d;
    logic [7:0]  frame_q [14];
    logic        send_start_q;
    logic        busy_q;
    logic        done_q;

    // ASCII character for each message type.
    function automatic logic [7:0] type_char(input logic [1:0] t);
        case (t)
            2'd0:    return 8'h53;  // 'S'
            2'd1:    return 8'h50;  // 'P'
            2'd2:    return 8'h44;  // 'D'
            default: return 8'h45;  // 'E'
        endcase
    endfunction

    // Uppercase hex character for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return 8'h37 + {4'h0, n};
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        logic [15:0] bcd_adj;
        logic [3:0]  nib;
        bcd_adj = 16'h0000;
        nib     = 4'h0;
        for (int i = 0; i < 4; i++) begin
            nib = sr_q[12 + 4*i +: 4];
            bcd_adj[4*i +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
        end
        sr_d = {bcd_adj[14:0], sr_q[11:0], 1'b0};
    end

    // Selects the frame byte that the checksum accumulates this cycle (index 1..10).
    always_comb begin
        cks_byte_d = 8'h00;
        case (cnt_q[3:0])
            4'd1:    cks_byte_d = frame_q[1];
            4'd2:    cks_byte_d = frame_q[2];
            4'd3:    cks_byte_d = frame_q[3];
            4'd4:    cks_byte_d = frame_q[4];
            4'd5:    cks_byte_d = frame_q[5];
            4'd6:    cks_byte_d = frame_q[6];
            4'd7:    cks_byte_d = frame_q[7];
            4'd8:    cks_byte_d = frame_q[8];
            4'd9:    cks_byte_d = frame_q[9];
            4'd10:   cks_byte_d = frame_q[10];
            default: cks_byte_d = 8'h00;
        endcase
    end

    // Main sequencer: conversion, frame assembly, checksum and wrapper handshake.
    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q      <= S_IDLE;
            type_q       <= 2'd0;
            node_q       <= 4'd0;
            sr_q         <= 28'd0;
            cnt_q        <= 16'd0;
            cks_q        <= 8'h00;
            send_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < 14; i++) frame_q[i] <= 8'h00;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        type_q  <= msg_type;
                        node_q  <= node_id;
                        sr_q    <= {16'd0, value};
                        cnt_q   <= 16'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    sr_q <= sr_d;
                    if (cnt_q == 16'd11) begin
                        cnt_q   <= 16'd0;
                        state_q <= S_ASM;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_ASM: begin
                    frame_q[0]  <= 8'h23;  // '#'
                    frame_q[1]  <= type_char(type_q);
                    frame_q[2]  <= 8'h2D;  // '-'
                    // Node digits come from a compare; node never exceeds 15.
                    frame_q[3]  <= (node_q >= 4'd10) ? 8'h31 : 8'h30;
                    frame_q[4]  <= 8'h30 + {4'h0, (node_q >= 4'd10) ? node_q - 4'd10 : node_q};
                    frame_q[5]  <= 8'h2D;
                    frame_q[6]  <= 8'h30 + {4'h0, sr_q[27:24]};
                    frame_q[7]  <= 8'h30 + {4'h0, sr_q[23:20]};
                    frame_q[8]  <= 8'h30 + {4'h0, sr_q[19:16]};
                    frame_q[9]  <= 8'h30 + {4'h0, sr_q[15:12]};
                    frame_q[10] <= 8'h2D;
                    frame_q[13] <= 8'h0A;
                    cks_q       <= 8'h00;
                    cnt_q       <= 16'd1;
                    state_q     <= S_CKS;
                end
                S_CKS: begin
                    cks_q <= cks_q ^ cks_byte_d;
                    if (cnt_q == 16'd10) begin
                        cnt_q   <= 16'd0;
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_FIN: begin
                    frame_q[11]  <= hex_char(cks_q[7:4]);
                    frame_q[12]  <= hex_char(cks_q[3:0]);
                    send_start_q <= 1'b1;
                    cnt_q        <= 16'd0;
                    state_q      <= S_START;
                end
                S_START: begin
                    if (cnt_q == 16'(START_HOLD - 1)) begin
                        send_start_q <= 1'b0;
                        cnt_q        <= 16'd0;
                        state_q      <= S_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_WAIT: begin
                    // No timeout: stays here until send_done or reset.
                    if (send_done) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign send_start = send_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign state_dbg  = state_q;
    assign data0      = frame_q[0];
    assign data1      = frame_q[1];
    assign data2      = frame_q[2];
    assign data3      = frame_q[3];
    assign data4      = frame_q[4];
    assign data5      = frame_q[5];
    assign data6      = frame_q[6];
    assign data7      = frame_q[7];
    assign data8      = frame_q[8];
    assign data9      = frame_q[9];
    assign data10     = frame_q[10];
    assign data11     = frame_q[11];
    assign data12     = frame_q[12];
    assign data13     = frame_q[13];

endmodule

// File: tb/tb_uart_msg_builder.sv
// Bench for uart_msg_builder: directed messages with hand-computed frames.
// Expected frames are queued at request time; a negedge monitor pops one
// frame and compares it whenever send_start rises.
module tb_uart_msg_builder;

    logic        clk_50M = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  msg_type;
    logic [3:0]  node_id;
    logic [11:0] value;
    logic        send_done;
    logic        send_start;
    logic [7:0]  data0, data1, data2, data3, data4, data5, data6;
    logic [7:0]  data7, data8, data9, data10, data11, data12, data13;
    logic        busy;
    logic        done;
    logic [2:0]  state_dbg;
    logic [111:0] frame;

    int total = 0;
    int bad   = 0;
    logic [111:0] exp_q[$];
    logic start_seen = 1'b0;

    // Hand-computed frames, byte 0 in the most significant position.
    localparam logic [111:0] F1 = 112'h23_53_2D_30_37_2D_30_31_32_33_2D_37_39_0A; // S,7,123
    localparam logic [111:0] F2 = 112'h23_45_2D_31_35_2D_34_30_39_35_2D_36_34_0A; // E,15,4095
    localparam logic [111:0] F3 = 112'h23_50_2D_30_30_2D_30_30_30_30_2D_37_44_0A; // P,0,0
    localparam logic [111:0] F4 = 112'h23_44_2D_31_30_2D_31_30_30_30_2D_36_39_0A; // D,10,1000
    localparam logic [111:0] F5 = 112'h23_53_2D_30_33_2D_30_30_34_32_2D_37_42_0A; // S,3,42
    localparam logic [111:0] F6 = 112'h23_50_2D_31_32_2D_34_30_30_30_2D_37_41_0A; // P,12,4000
    localparam logic [111:0] F7 = 112'h23_44_2D_30_35_2D_30_30_30_37_2D_36_42_0A; // D,5,7

    uart_msg_builder #(.START_HOLD(32)) dut (
        .clk_50M    (clk_50M),
        .reset      (reset),
        .req        (req),
        .msg_type   (msg_type),
        .node_id    (node_id),
        .value      (value),
        .send_done  (send_done),
        .send_start (send_start),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .data4      (data4),
        .data5      (data5),
        .data6      (data6),
        .data7      (data7),
        .data8      (data8),
        .data9      (data9),
        .data10     (data10),
        .data11     (data11),
        .data12     (data12),
        .data13     (data13),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    assign frame = {data0, data1, data2, data3, data4, data5, data6,
                    data7, data8, data9, data10, data11, data12, data13};

    // Clock / reset block
    always #10 clk_50M = ~clk_50M;

    // Scoreboard monitor: one frame popped per send_start rising edge.
    always @(negedge clk_50M) begin
        if (send_start && !start_seen) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_send: frame %h sent with nothing expected", frame);
            end else begin
                logic [111:0] e;
                e = exp_q.pop_front();
                if (frame !== e) begin
                    bad++;
                    $display("FAIL frame: got %h, required %h", frame, e);
                end
            end
        end
        start_seen = send_start;
    end

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check_idle(input string name);
        check({name, "_ctl"}, {61'd0, send_start, busy, done}, 112'd0);
        check({name, "_data"}, frame, 112'd0);
    endtask

    // Driver: one-cycle req; expected frame is queued as the request is issued.
    task automatic issue(input logic [1:0] t, input logic [3:0] n, input logic [11:0] v,
                         input logic [111:0] f);
        msg_type = t;
        node_id  = n;
        value    = v;
        req      = 1'b1;
        exp_q.push_back(f);
        tick();
        req = 1'b0;
    endtask

    task automatic wait_rise(input string name);
        int c = 0;
        while (!send_start && c < 200) begin tick(); c++; end
        check(name, {111'd0, send_start}, 112'd1);
    endtask

    task automatic wait_fall(input string name);
        int c = 0;
        while (send_start && c < 200) begin tick(); c++; end
        check(name, {111'd0, send_start}, 112'd0);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!done && c < 200) begin tick(); c++; end
        check(name, {111'd0, done}, 112'd1);
        tick();
    endtask

    initial begin
        int n;
        int len;
        int pulses;
        logic stable;
        reset = 1'b1; req = 1'b0; msg_type = 2'd0; node_id = 4'd0;
        value = 12'd0; send_done = 1'b0;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;

        // Checksum frame with exact send_start timing
        issue(2'd0, 4'd7, 12'd123, F1);
        check("t1_busy_rise", {111'd0, busy}, 112'd1);
        n = 1;
        while (!send_start && n < 200) begin tick(); n++; end
        check("t1_start_latency", n, 25);
        len = 0;
        while (send_start && len < 200) begin
            len++;
            if (len == 20) send_done = 1'b1;
            tick();
        end
        check("t1_start_len", len, 32);
        check("t1_done_in_wait", {111'd0, done}, 112'd0);
        tick();
        check("t1_done_pulse", {110'd0, done, busy}, 112'd3);
        tick();
        check("t1_after_done", {110'd0, done, busy}, 112'd0);
        send_done = 1'b0;

        // Maximum and minimum values
        send_done = 1'b1;
        issue(2'd3, 4'd15, 12'd4095, F2);
        wait_done("t2_done");
        issue(2'd1, 4'd0, 12'd0, F3);
        wait_done("t3_done");
        send_done = 1'b0;

        // Long handshake: outputs stable while send_done stays low
        issue(2'd2, 4'd10, 12'd1000, F4);
        wait_rise("t4_rise");
        wait_fall("t4_fall");
        stable = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (busy !== 1'b1 || frame !== F4 || done !== 1'b0 || send_start !== 1'b0)
                stable = 1'b0;
            tick();
        end
        check("t4_stable", {111'd0, stable}, 112'd1);
        send_done = 1'b1;
        tick();
        check("t4_done_edge", {111'd0, done}, 112'd1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) pulses++;
        end
        check("t4_single_pulse", pulses, 0);
        check("t4_idle_busy", {111'd0, busy}, 112'd0);
        send_done = 1'b0;

        // Request during CONV is ignored
        send_done = 1'b1;
        issue(2'd0, 4'd3, 12'd42, F5);
        tick();
        tick();
        msg_type = 2'd3; node_id = 4'd9; value = 12'd999; req = 1'b1;
        tick();
        req = 1'b0;
        wait_done("t5_done");
        for (int i = 0; i < 100; i++) tick();
        check("t5_idle_busy", {111'd0, busy}, 112'd0);
        send_done = 1'b0;

        // Reset abort during START, then during WAIT
        issue(2'd1, 4'd12, 12'd4000, F6);
        wait_rise("t6_rise_a");
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        check_idle("t6_abort_start");
        reset = 1'b0;
        issue(2'd2, 4'd5, 12'd7, F7);
        wait_rise("t6_rise_b");
        wait_fall("t6_fall_b");
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        check_idle("t6_abort_wait");
        reset = 1'b0;
        send_done = 1'b1;
        issue(2'd0, 4'd7, 12'd123, F1);
        wait_done("t6_fresh_done");
        send_done = 1'b0;
        tick();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_msg_builder.md
# uart_msg_builder

Formats one telemetry message into the fixed 14-byte ASCII frame consumed by the UART transmit wrapper, then runs the start/done handshake with that wrapper. It sits directly upstream of the wrapper: its 14 byte outputs drive the wrapper's data0..data13, and its send_start drives the wrapper's start. Values are converted to decimal with a sequential double-dabble, and the frame carries an XOR checksum.

## Interface
- START_HOLD, 32: clk_50M cycles that send_start is held high. Must be ≥ 2 periods of the 3.125 MHz transmit clock, i.e. ≥ 32.
- clk_50M  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- req  in  1  one-cycle request; sampled only in IDLE.
- msg_type  in  2  0='S', 1='P', 2='D', 3='E'.
- node_id  in  4  node number 0..15.
- value  in  12  payload 0..4095.
- send_done  in  1  level from the transmit wrapper; high once the frame is fully sent.
- send_start  out  1  start request to the transmit wrapper.
- data0..data13  out  8 each  frame bytes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the handshake completes.

## Operation
- Frame layout (ASCII):
  - byte 0 = '#'
  - byte 1 = type character
  - byte 2 = '-'
  - bytes 3-4 = node_id as two decimal digits, 00..15
  - byte 5 = '-'
  - bytes 6-9 = value as four decimal digits, 0000..4095
  - byte 10 = '-'
  - bytes 11-12 = checksum as two uppercase hex characters, high nibble first
  - byte 13 = 0x0A
- Checksum = XOR of bytes 1..10.
- State machine:
  - IDLE: wait for req.
  - CONV: 12 cycles, one double-dabble shift per cycle on {BCD[15:0], value}. Before each shift, add 3 to any BCD nibble that is ≥ 5.
  - ASM: 1 cycle; write bytes 0..10 and 13. Digit byte = 0x30 + BCD nibble.
  - CKS: 10 cycles; accumulate XOR of bytes 1..10, one byte per cycle.
  - FIN: 1 cycle; write bytes 11-12. Hex encoding: nibble 0-9 → 0x30+n, nibble A-F → 0x37+n.
  - START: hold send_start=1 for START_HOLD cycles.
  - WAIT: send_start=0; wait for send_done=1.
  - DONE: done=1 for 1 cycle, then return to IDLE.
- Node digits come from a compare, not double-dabble: node ≥ 10 → tens='1', ones = node−10.
- msg_type, node_id and value are latched on the accepting req edge. Later input changes have no effect on the frame in progress.
- data0..data13 change only in ASM and FIN. They hold their value from FIN until the next ASM, so they are stable throughout START and WAIT.
- req while busy: ignored, not queued.
- send_done already high on entry to WAIT: leave WAIT on the next edge.
- There is no timeout. If send_done never rises, the block stays in WAIT until reset.

## Timing
- Reset values:
  - state = IDLE
  - send_start = 0, busy = 0, done = 0
  - all data bytes = 0x00
  - BCD, checksum and counters = 0
- Reset applies on any edge and aborts any state, including START. send_start falls in the cycle after reset is sampled.
- Counting from the req-sampling edge k:
  - CONV occupies k+1..k+12
  - ASM k+13
  - CKS k+14..k+23
  - FIN k+24
  - send_start=1 during k+25..k+24+START_HOLD
  - earliest done at k+26+START_HOLD
- busy rises at k+1 and falls on the cycle after the done pulse.
- req may be asserted on the cycle after done. The minimum period between accepted requests is 27+START_HOLD cycles plus the WAIT duration.
- All outputs are registered.

## Test plan
- Checksum frame: reset, then req with type=0, node=7, value=123. Required frame bytes 0..13 = 23 53 2D 30 37 2D 30 31 32 33 2D 37 39 0A. send_start rises at k+25 and lasts exactly 32 cycles.
- Maximum values: type=3, node=15, value=4095. Required bytes 1..10 = 'E' '-' '1' '5' '-' '4' '0' '9' '5' '-'. Checksum bytes must match an XOR reference model.
- Minimum values: type=1, node=0, value=0. Required digits "00" and "0000".
- Handshake: hold send_done low for 500 cycles after START. busy and frame bytes stay stable throughout. Raise send_done: done pulses exactly once, on the next edge after send_done is sampled high.
- Ignored request: pulse req during CONV with different inputs. The frame reflects only the first request, and no second send follows.
- Reset abort: assert reset during START, then during WAIT. All outputs return to their reset values on the next edge. A fresh req afterwards produces a correct frame.
